ip_msxbus_initiator: RTL
========================

# ip_msxbus_initiator

Cartridge-edge to MSX-50BUS bridge: samples the Z80-side strobes on the cartridge connector, turns each qualified memory or I/O cycle into a single internal-bus request, and returns read data to the connector. It is the initiator that drives every internal-bus responder, including the expanded-slot register and the page-select logic behind it. It sits between the pin-level I/O buffers and all `bus_*` responders in the top level.

## Interface

**Parameters**

- `TIMEOUT`, default 16: clock cycles to wait in `RD_WAIT` for `bus_read_ready` before returning the default read data.
- `DEFAULT_DATA`, default 8'hFF: read data returned on timeout.

**Ports.** Clock and reset:

- `clk`  in  1  system clock.
- `n_reset`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.

Cartridge pins (asynchronous to `clk`):

- `p_adr`  in  16  Z80 address.
- `p_d_in`  in  8  Z80 write data.
- `p_d_out`  out  8  read data to the connector.
- `p_d_oe`  out  1  data bus output enable, high = drive.
- `p_n_sltsl`  in  1  slot select, active-low.
- `p_n_merq`  in  1  memory request, active-low.
- `p_n_iorq`  in  1  I/O request, active-low.
- `p_n_m1`  in  1  M1 cycle indicator, active-low.
- `p_n_rd`  in  1  read strobe, active-low.
- `p_n_wr`  in  1  write strobe, active-low.
- `p_n_wait`  out  1  WAIT request, active-low.

Internal bus:

- `bus_address`  out  16  latched address.
- `bus_write_data`  out  8  latched write data.
- `bus_read`  out  1  read request pulse.
- `bus_write`  out  1  write request pulse.
- `bus_memory`  out  1  memory-space qualifier.
- `bus_io`  out  1  I/O-space qualifier.
- `bus_read_ready`  in  1  responder read-data valid.
- `bus_read_data`  in  8  responder read data; OR of all responders, 0 when idle.

## Operation

- **Synchronisation.** The six control pins pass through 2-FF synchronisers. Address and data are captured directly from the pins at request time; they are stable well before the strobes propagate.
- **Cycle qualification** (on synchronised signals):
  - Memory cycle: `sltsl`=0, `merq`=0, and `rd`=0 or `wr`=0.
  - I/O cycle: `iorq`=0, `m1`=1, and `rd`=0 or `wr`=0.
  - `iorq`=0 with `m1`=0 (interrupt acknowledge) is ignored.
  - If both `rd` and `wr` are low, read wins.
- **State machine:** `IDLE`, `RD_REQ`, `RD_WAIT`, `WR_REQ`, `HOLD`.
  - `IDLE`: on a qualified read, latch `bus_address` and go to `RD_REQ`. On a qualified write, latch `bus_address` and `bus_write_data` and go to `WR_REQ`.
  - `RD_REQ`: `bus_read`=1 for exactly this cycle. Clear the timeout counter. Go to `RD_WAIT`.
  - `RD_WAIT`: `bus_read_ready`=1 is sampled the same cycle `RD_REQ` exits at the earliest. On `bus_read_ready`=1, latch `bus_read_data` into `p_d_out` and go to `HOLD`. Otherwise increment the counter. When the counter reaches `TIMEOUT`-1 without ready, latch `DEFAULT_DATA` and go to `HOLD`.
  - `WR_REQ`: `bus_write`=1 for exactly this cycle, then go to `HOLD`.
  - `HOLD`: wait until the synchronised `rd` and `wr` are both high, then go to `IDLE`. This guarantees one internal request per Z80 strobe.
- **Space qualifiers.** `bus_memory`/`bus_io` are 1 in `RD_REQ`, `RD_WAIT` and `WR_REQ` according to the latched cycle type, and 0 otherwise.
- **Data drive.** `p_d_oe`=1 from entry to `HOLD` after a read until `HOLD` exits. It is 0 in all other states and after writes.
- **Ready outside a read.** A `bus_read_ready` pulse arriving outside `RD_WAIT` is ignored.
- **Counter width:** `$clog2(TIMEOUT)`. Saturating; never wraps.

## Timing

- **Reset values:**
  - `bus_address`=0, `bus_write_data`=0.
  - `bus_read`=`bus_write`=`bus_memory`=`bus_io`=0.
  - `p_d_out`=0, `p_d_oe`=0, `p_n_wait`=1.
  - State `IDLE`; synchronisers cleared to inactive, i.e. 1.
- **Strobe detection:** a pin falling edge is seen in `IDLE` 2 clocks later.
  - `bus_read`/`bus_write` rise on the clock edge after that, i.e. 3 clocks after the pin edge.
- **Zero-wait responder:** a responder with 1-cycle ready latency (ready in the cycle after `bus_read`) gives `p_d_oe`=1 five clocks after the `rd` pin falls.
- **Reset mid-operation:** asserting `n_reset` in any state returns all outputs to reset values immediately (asynchronously). After release, a strobe still held low is treated as a new cycle only once it is seen in `IDLE`.

## Configuration

- `IP_MSXBUS_INITIATOR_WAIT_EN` defined:
  - `p_n_wait` is driven 0 from the cycle a qualified read is detected in `IDLE` until `HOLD` is entered.
  - Writes never assert WAIT.
- Macro undefined: `p_n_wait` is tied to 1. Only reads shorter than the host strobe are supported.

## Test plan

- **Memory read with ready.** Drive `p_adr`=FFFF, `sltsl`/`merq`/`rd` low; responder returns ready=1, data=5A one cycle after `bus_read`. Required: exactly one `bus_read` pulse with `bus_memory`=1 and `bus_address`=FFFF; `p_d_out`=5A and `p_d_oe`=1 until `rd` rises; `p_d_oe`=0 two to three clocks after that.
- **Memory write.** Drive `p_adr`=FFFF, `p_d_in`=A5, `wr` low for 20 clocks. Required: exactly one `bus_write` pulse with `bus_write_data`=A5 and `bus_memory`=1; `p_d_oe` stays 0.
- **Read timeout.** I/O read to port 98 with no responder. Required: `bus_io`=1; after `TIMEOUT`=16 cycles in `RD_WAIT`, `p_d_out`=FF and `p_d_oe`=1.
- **Interrupt acknowledge.** `iorq`=0, `m1`=0, `rd`=0. Required: no `bus_read`, no `bus_io`, `p_d_oe` stays 0.
- **WAIT.** With `WAIT_EN` defined, responder delays ready 6 cycles. Required: `p_n_wait`=0 from detection until the `HOLD` entry cycle. With the macro undefined, `p_n_wait` stays 1.
- **Reset during read.** Assert `n_reset` in `RD_WAIT`. Required: `p_d_oe`=0, `p_n_wait`=1 and `bus_memory`=0 with no clock edge; no spurious `bus_read` after release while the strobe stays high.

Source files
------------

// File: rtl/ip_msxbus_initiator.sv
// Cartridge-edge to MSX-50BUS initiator: one internal request per Z80 strobe.
// Optional WAIT generation on reads: define IP_MSXBUS_INITIATOR_WAIT_EN.
`timescale 1ns/1ps
module ip_msxbus_initiator #(
    parameter int          TIMEOUT      = 16,
    parameter logic [7:0]  DEFAULT_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] p_adr,
    input  logic [7:0]  p_d_in,
    output logic [7:0]  p_d_out,
    output logic        p_d_oe,
    input  logic        p_n_sltsl,
    input  logic        p_n_merq,
    input  logic        p_n_iorq,
    input  logic        p_n_m1,
    input  logic        p_n_rd,
    input  logic        p_n_wr,
    output logic        p_n_wait,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_write_data,
    output logic        bus_read,
    output logic        bus_write,
    output logic        bus_memory,
    output logic        bus_io,
    input  logic        bus_read_ready,
    input  logic [7:0]  bus_read_data
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, HOLD
    } state_t;

    state_t state, next;

    logic [5:0]    sync1, sync2;
    logic          s_sltsl, s_merq, s_iorq, s_m1, s_rd, s_wr;
    logic          mem_cyc, io_cyc, rd_go, wr_go;
    logic          is_read, is_mem, active;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {p_n_sltsl, p_n_merq, p_n_iorq, p_n_m1, p_n_rd, p_n_wr};
            sync2 <= sync1;
        end
    end

    assign {s_sltsl, s_merq, s_iorq, s_m1, s_rd, s_wr} = sync2;

    // Interrupt acknowledge (iorq with m1 low) never qualifies as I/O.
    assign mem_cyc = !s_sltsl && !s_merq && (!s_rd || !s_wr);
    assign io_cyc  = !s_iorq && s_m1 && (!s_rd || !s_wr);
    assign rd_go   = (mem_cyc || io_cyc) && !s_rd;
    assign wr_go   = (mem_cyc || io_cyc) && s_rd && !s_wr;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (rd_go)      next = RD_REQ;
                else if (wr_go) next = WR_REQ;
            end
            RD_REQ:  next = RD_WAIT;
            RD_WAIT: if (bus_read_ready || cnt == LAST) next = HOLD;
            WR_REQ:  next = HOLD;
            HOLD:    if (s_rd && s_wr) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bus_address    <= '0;
            bus_write_data <= '0;
            p_d_out        <= '0;
            is_read        <= 1'b0;
            is_mem         <= 1'b0;
            cnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_go || wr_go) begin
                        bus_address <= p_adr;
                        is_mem      <= mem_cyc;
                        is_read     <= rd_go;
                    end
                    if (!rd_go && wr_go) bus_write_data <= p_d_in;
                end
                RD_REQ: cnt <= '0;
                RD_WAIT: begin
                    if (bus_read_ready)   p_d_out <= bus_read_data;
                    else if (cnt == LAST) p_d_out <= DEFAULT_DATA;
                    else                  cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign active     = (state == RD_REQ) || (state == RD_WAIT) ||
                        (state == WR_REQ);
    assign bus_read   = (state == RD_REQ);
    assign bus_write  = (state == WR_REQ);
    assign bus_memory = active && is_mem;
    assign bus_io     = active && !is_mem;
    assign p_d_oe     = (state == HOLD) && is_read;

`ifdef IP_MSXBUS_INITIATOR_WAIT_EN
    assign p_n_wait = !(((state == IDLE) && rd_go) ||
                        (state == RD_REQ) || (state == RD_WAIT));
`else
    assign p_n_wait = 1'b1;
`endif

endmodule
